imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 21 ++
 rtl/imm_format_unit.sv | 28 ++
 rtl/imm_decode_stage.sv | 127 ++++++++++++
 tb/tb_imm_decode_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared select codes and pipeline state encoding for the immediate decode stage.
package imm_pkg;

   typedef enum logic [2:0] {
      SEL_U     = 3'b000,
      SEL_I     = 3'b001,
      SEL_SHAMT = 3'b010,
      SEL_S     = 3'b011,
      SEL_B     = 3'b100,
      SEL_J     = 3'b101,
      SEL_ZIMM  = 3'b110,
      SEL_ZERO  = 3'b111
   } imm_sel_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

endpackage

// File: rtl/imm_format_unit.sv
// Combinational extraction and extension of an instruction immediate to XLEN bits.
import imm_pkg::*;

module imm_format_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:7]     instr,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      // Size casts of signed operands sign-extend; of unsigned ones zero-extend.
      case (imm_sel_e'(sel))
         SEL_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
         SEL_I:     imm = XLEN'($signed(instr[31:20]));
         SEL_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
         SEL_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         SEL_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         SEL_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         SEL_ZIMM:  imm = XLEN'(instr[19:15]);
         SEL_ZERO:  imm = '0;
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: extends on the input side, buffers in a main + skid register pair.
import imm_pkg::*;

module imm_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_sel,
   output logic [TAG_W-1:0] out_tag
);

   stage_state_e     state_q, state_d;
   logic [XLEN-1:0]  main_imm_q, skid_imm_q, ext_imm;
   logic [2:0]       main_sel_q, skid_sel_q;
   logic [TAG_W-1:0] main_tag_q, skid_tag_q;
   logic             in_xfer, out_xfer;
   logic             load_main, load_skid, move_skid, clear;
   logic             unused_opcode;

   // Opcode field carries no immediate bits.
   assign unused_opcode = ^in_instr[6:0];

   imm_format_unit #(.XLEN(XLEN)) u_format (
      .instr (in_instr[31:7]),
      .sel   (in_sel),
      .imm   (ext_imm)
   );

   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_imm   = main_imm_q;
   assign out_sel   = main_sel_q;
   assign out_tag   = main_tag_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      clear     = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (in_xfer) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_xfer) begin
               state_d   = ST_ONE;
               move_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins over any transfer decided above.
      if (flush) begin
         state_d   = ST_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         move_skid = 1'b0;
         clear     = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_EMPTY;
         main_imm_q <= '0;
         main_sel_q <= '0;
         main_tag_q <= '0;
         skid_imm_q <= '0;
         skid_sel_q <= '0;
         skid_tag_q <= '0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            main_imm_q <= '0;
            main_sel_q <= '0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_sel_q <= '0;
            skid_tag_q <= '0;
         end else begin
            if (load_main) begin
               main_imm_q <= ext_imm;
               main_sel_q <= in_sel;
               main_tag_q <= in_tag;
            end else if (move_skid) begin
               main_imm_q <= skid_imm_q;
               main_sel_q <= skid_sel_q;
               main_tag_q <= skid_tag_q;
            end
            if (load_skid) begin
               skid_imm_q <= ext_imm;
               skid_sel_q <= in_sel;
               skid_tag_q <= in_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 stages driven in lockstep against a FIFO reference model.
module tb_imm_decode_stage;

   localparam int unsigned TW = 32;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          in_valid, out_ready, flush;
   logic [31:0]   in_instr;
   logic [2:0]    in_sel;
   logic [TW-1:0] in_tag;

   logic          in_ready32, out_valid32, in_ready64, out_valid64;
   logic [31:0]   out_imm32;
   logic [63:0]   out_imm64;
   logic [2:0]    out_sel32, out_sel64;
   logic [TW-1:0] out_tag32, out_tag64;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      bit [31:0]   instr;
      bit [2:0]    sel;
      bit [TW-1:0] tag;
   } entry_t;

   entry_t q[$];

   always #5 CLK = ~CLK;

   imm_decode_stage #(.XLEN(32), .TAG_W(TW)) dut32 (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_sel(out_sel32), .out_tag(out_tag32)
   );

   imm_decode_stage #(.XLEN(64), .TAG_W(TW)) dut64 (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_sel(out_sel64), .out_tag(out_tag64)
   );

   // Immediate value as a signed integer, assembled field by field.
   function automatic bit [63:0] ref_imm(bit [31:0] ins, bit [2:0] sel, int xlen);
      longint sl, v;
      sl = longint'(signed'(ins));
      case (sel)
         3'd0: v = (sl >>> 12) <<< 12;
         3'd1: v = sl >>> 20;
         3'd2: v = longint'((ins >> 20) & ((xlen == 64) ? 32'h3F : 32'h1F));
         3'd3: v = ((sl >>> 25) <<< 5) | longint'((ins >> 7) & 32'h1F);
         3'd4: v = ((sl >>> 31) <<< 12) | longint'((((ins >> 7) & 1) << 11) |
                   (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1));
         3'd5: v = ((sl >>> 31) <<< 20) | longint'((((ins >> 12) & 32'hFF) << 12) |
                   (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1));
         3'd6: v = longint'((ins >> 15) & 32'h1F);
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_outputs(string name);
      bit [63:0] e32, e64;
      chk({name, ".valid32"}, 64'(out_valid32), 64'(q.size() != 0));
      chk({name, ".valid64"}, 64'(out_valid64), 64'(q.size() != 0));
      chk({name, ".ready32"}, 64'(in_ready32), 64'(q.size() < 2));
      chk({name, ".ready64"}, 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() != 0) begin
         e32 = ref_imm(q[0].instr, q[0].sel, 32);
         e64 = ref_imm(q[0].instr, q[0].sel, 64);
         chk({name, ".imm32"}, 64'(out_imm32), 64'(e32[31:0]));
         chk({name, ".imm64"}, out_imm64, e64);
         chk({name, ".sel"}, 64'({out_sel32, out_sel64}), 64'({q[0].sel, q[0].sel}));
         chk({name, ".tag32"}, 64'(out_tag32), 64'(q[0].tag));
         chk({name, ".tag64"}, 64'(out_tag64), 64'(q[0].tag));
      end
   endtask

   // One clock: decide transfers from the inputs in force, then update the model.
   task automatic advance();
      bit     do_out, do_in, do_flush;
      entry_t e;
      do_out   = (q.size() > 0) && out_ready;
      do_in    = in_valid && (q.size() < 2);
      do_flush = flush;
      e.instr  = in_instr;
      e.sel    = in_sel;
      e.tag    = in_tag;
      @(posedge CLK);
      #1;
      if (do_flush) q.delete();
      else begin
         if (do_out) void'(q.pop_front());
         if (do_in) q.push_back(e);
      end
   endtask

   task automatic check_reset(string name);
      chk({name, ".valid"}, 64'({out_valid32, out_valid64}), 64'd0);
      chk({name, ".ready"}, 64'({in_ready32, in_ready64}), 64'd3);
      chk({name, ".imm32"}, 64'(out_imm32), 64'd0);
      chk({name, ".imm64"}, out_imm64, 64'd0);
      chk({name, ".sel"}, 64'({out_sel32, out_sel64}), 64'd0);
      chk({name, ".tag"}, 64'(out_tag32 | out_tag64), 64'd0);
   endtask

   bit [31:0] dir_instr [6] = '{32'hFFF00093, 32'h80000063, 32'h800000EF,
                                32'hFE000FA3, 32'h43F05013, 32'h800002B7};
   bit [2:0]  dir_sel   [6] = '{3'd1, 3'd4, 3'd5, 3'd3, 3'd2, 3'd0};
   bit [31:0] dir_exp32 [6] = '{32'hFFFFFFFF, 32'hFFFFF000, 32'hFFF00000,
                                32'hFFFFFFFF, 32'h0000001F, 32'h80000000};
   bit [63:0] dir_exp64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF000,
                                64'hFFFFFFFFFFF00000, 64'hFFFFFFFFFFFFFFFF,
                                64'h000000000000003F, 64'hFFFFFFFF80000000};

   initial begin
      RESET_N   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_instr  = '0;
      in_sel    = '0;
      in_tag    = '0;
      #1;
      check_reset("reset");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Spec vectors, one at a time with downstream always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_instr = dir_instr[i];
         in_sel   = dir_sel[i];
         in_tag   = 32'h100 + i;
         advance();
         chk($sformatf("dir%0d.imm32", i), 64'(out_imm32), 64'(dir_exp32[i]));
         chk($sformatf("dir%0d.imm64", i), out_imm64, dir_exp64[i]);
         check_outputs($sformatf("dir%0d", i));
         in_valid = 1'b0;
         advance();
         check_outputs($sformatf("dir%0d.drain", i));
      end

      // Backpressure: A then B fill both registers, outputs hold A.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hABC00093;
      in_sel    = 3'd1;
      in_tag    = 32'hA;
      advance();
      check_outputs("bp.a");
      in_instr  = 32'h12345037;
      in_sel    = 3'd0;
      in_tag    = 32'hB;
      advance();
      check_outputs("bp.ab");
      chk("bp.tag_a", 64'(out_tag32), 64'hA);
      in_instr  = 32'hFFFFFFFF;
      in_tag    = 32'hC;
      advance();
      check_outputs("bp.hold");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      advance();
      check_outputs("bp.b");
      chk("bp.tag_b", 64'(out_tag32), 64'hB);
      advance();
      check_outputs("bp.empty");

      // Flush while full, with a competing input.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_tag    = 32'hD1;
      advance();
      in_tag    = 32'hD2;
      advance();
      check_outputs("fl.full");
      flush = 1'b1;
      advance();
      chk("fl.valid", 64'(out_valid32), 64'd0);
      check_outputs("fl.after");
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      advance();
      check_outputs("fl.idle");

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_instr  = $urandom;
         in_sel    = 3'($urandom_range(0, 7));
         in_tag    = $urandom;
         advance();
         check_outputs("rnd");
      end
      flush = 1'b0;

      // Asynchronous reset while holding one entry.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      in_sel    = 3'd1;
      in_tag    = 32'hE;
      advance();
      in_valid  = 1'b0;
      check_outputs("ar.one");
      #2 RESET_N = 1'b0;
      #1;
      q.delete();
      check_reset("ar.async");
      @(negedge CLK);
      RESET_N   = 1'b1;
      out_ready = 1'b1;
      advance();
      check_outputs("ar.release");
      chk("ar.no_output", 64'(out_valid32 | out_valid64), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
